nmcu_matmul_seq: RTL and testbench

- Command-level sequencer in front of the NMCU instruction port.
- Accepts one matrix-multiply command: base addresses of A, B and C plus dimension N.
- Expands it into N×N `INSTR_MAC` instructions, issued one at a time over the NMCU valid/ready instruction handshake, collecting each response.
- Reports one completion with status and element count; aborts on the first failing response.

---
 rtl/nmcu_matmul_seq.sv | 187 ++++++++++++++++++
 tb/tb_nmcu_matmul_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nmcu_matmul_seq.sv
// rtl/nmcu_matmul_seq.sv - matrix-multiply command sequencer in front of the NMCU instruction port
// Optional feature macro: NMCU_MATMUL_SEQ_TIMEOUT_EN (response timeout, status 11).
// Ports:
//   clk, rst                        sole clock; synchronous active-high reset
//   cmd_valid_i / cmd_ready_o       command handshake
//   cmd_base_a/b/c_i, cmd_dim_i     row-major bases (B stored transposed) and dimension N
//   instr_valid_o / instr_ready_i   instruction handshake, instr_o carries one INSTR_MAC
//   rsp_valid_i / rsp_ready_o       response handshake, only rsp_i.status is used
//   done_valid_o / done_ready_i     completion handshake with done_status_o, done_count_o
//   busy_o                          FSM not in IDLE

package nmcu_pkg;
  localparam int ADDR_WIDTH = 16;
  localparam int LEN_WIDTH  = 8;
  localparam int DATA_WIDTH = 32;
endpackage

package instr_pkg;
  typedef enum logic [2:0] {
    INSTR_NOP   = 3'd0,
    INSTR_LOAD  = 3'd1,
    INSTR_STORE = 3'd2,
    INSTR_MAC   = 3'd3
  } opcode_t;

  typedef struct packed {
    opcode_t                         opcode;
    logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_a;
    logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_b;
    logic [nmcu_pkg::ADDR_WIDTH-1:0] addr_c;
    logic [nmcu_pkg::LEN_WIDTH-1:0]  len;
    logic [nmcu_pkg::DATA_WIDTH-1:0] data;
  } instruction_t;

  typedef struct packed {
    logic [1:0]                      status;
    logic [nmcu_pkg::DATA_WIDTH-1:0] data;
  } nmcu_cpu_resp_t;
endpackage

module nmcu_matmul_seq #(
  parameter int ADDR_WIDTH     = nmcu_pkg::ADDR_WIDTH,
  parameter int LEN_WIDTH      = nmcu_pkg::LEN_WIDTH,
  parameter int MAX_DIM        = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_a_i,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_b_i,
  input  logic [ADDR_WIDTH-1:0]        cmd_base_c_i,
  input  logic [LEN_WIDTH-1:0]         cmd_dim_i,
  output logic                         instr_valid_o,
  output instr_pkg::instruction_t      instr_o,
  input  logic                         instr_ready_i,
  input  logic                         rsp_valid_i,
  input  instr_pkg::nmcu_cpu_resp_t    rsp_i,
  output logic                         rsp_ready_o,
  output logic                         done_valid_o,
  output logic [1:0]                   done_status_o,
  output logic [2*LEN_WIDTH-1:0]       done_count_o,
  input  logic                         done_ready_i,
  output logic                         busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   a_ptr_q, b_ptr_q, c_ptr_q, base_b_q;
  logic [LEN_WIDTH-1:0]    dim_q, i_q, j_q;
  logic [2*LEN_WIDTH-1:0]  count_q;
  logic [1:0]              status_q;

  logic cmd_fire, instr_fire, rsp_fire, rsp_ok, last_elem, row_end, dim_bad, dim_zero, timed_out;

  assign cmd_fire   = (state_q == IDLE) && cmd_valid_i;
  assign instr_fire = (state_q == ISSUE) && instr_ready_i;
  assign rsp_fire   = (state_q == WAIT_RSP) && rsp_valid_i;
  assign rsp_ok     = (rsp_i.status == 2'b00);
  assign row_end    = (j_q == dim_q - LEN_WIDTH'(1));
  assign last_elem  = row_end && (i_q == dim_q - LEN_WIDTH'(1));
  assign dim_zero   = (cmd_dim_i == '0);
  assign dim_bad    = (cmd_dim_i > LEN_WIDTH'(MAX_DIM));

  logic unused_rsp_data;
  assign unused_rsp_data = ^rsp_i.data;

`ifdef NMCU_MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  // Timer counts completed WAIT_RSP cycles; expiry fires on the last one without a handshake.
  assign timed_out = (state_q == WAIT_RSP) && !rsp_valid_i && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || instr_fire) timer_q <= '0;
    else if (state_q == WAIT_RSP) timer_q <= timer_q + TW'(1);
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_valid_i) state_d = (dim_zero || dim_bad) ? DONE : ISSUE;
      ISSUE:    if (instr_ready_i) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_valid_i) state_d = (!rsp_ok || last_elem) ? DONE : ISSUE;
        else if (timed_out) state_d = DONE;
      end
      DONE:     if (done_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Datapath: pointers advance incrementally so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ptr_q  <= '0;
      b_ptr_q  <= '0;
      c_ptr_q  <= '0;
      base_b_q <= '0;
      dim_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      count_q  <= '0;
      status_q <= 2'b00;
    end else if (cmd_fire) begin
      a_ptr_q  <= cmd_base_a_i;
      b_ptr_q  <= cmd_base_b_i;
      c_ptr_q  <= cmd_base_c_i;
      base_b_q <= cmd_base_b_i;
      dim_q    <= cmd_dim_i;
      i_q      <= '0;
      j_q      <= '0;
      count_q  <= '0;
      status_q <= dim_bad ? 2'b10 : 2'b00;
    end else if (rsp_fire) begin
      if (rsp_ok) begin
        count_q <= count_q + (2*LEN_WIDTH)'(1);
        c_ptr_q <= c_ptr_q + ADDR_WIDTH'(1);
        if (!row_end) begin
          j_q     <= j_q + LEN_WIDTH'(1);
          b_ptr_q <= b_ptr_q + ADDR_WIDTH'(dim_q);
        end else begin
          j_q     <= '0;
          b_ptr_q <= base_b_q;
          i_q     <= i_q + LEN_WIDTH'(1);
          a_ptr_q <= a_ptr_q + ADDR_WIDTH'(dim_q);
        end
      end else begin
        status_q <= rsp_i.status;
      end
    end else if (timed_out) begin
      status_q <= 2'b11;
    end
  end

  always_comb begin
    instr_o = '0;
    if (state_q == ISSUE) begin
      instr_o.opcode = instr_pkg::INSTR_MAC;
      instr_o.addr_a = nmcu_pkg::ADDR_WIDTH'(a_ptr_q);
      instr_o.addr_b = nmcu_pkg::ADDR_WIDTH'(b_ptr_q);
      instr_o.addr_c = nmcu_pkg::ADDR_WIDTH'(c_ptr_q);
      instr_o.len    = nmcu_pkg::LEN_WIDTH'(dim_q);
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign instr_valid_o = (state_q == ISSUE);
  assign rsp_ready_o   = (state_q == WAIT_RSP);
  assign done_valid_o  = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign done_status_o = status_q;
  assign done_count_o  = count_q;

endmodule

// File: tb/tb_nmcu_matmul_seq.sv
// tb/tb_nmcu_matmul_seq.sv - directed self-checking bench for nmcu_matmul_seq with an NMCU model
module tb_nmcu_matmul_seq;

  localparam int TMO = 5000;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        cmd_valid_i = 1'b0;
  logic                        cmd_ready_o;
  logic [15:0]                 cmd_base_a_i = '0, cmd_base_b_i = '0, cmd_base_c_i = '0;
  logic [7:0]                  cmd_dim_i = '0;
  logic                        instr_valid_o;
  instr_pkg::instruction_t     instr_o;
  logic                        instr_ready_i = 1'b0;
  logic                        rsp_valid_i = 1'b0;
  instr_pkg::nmcu_cpu_resp_t   rsp_i = '0;
  logic                        rsp_ready_o;
  logic                        done_valid_o;
  logic [1:0]                  done_status_o;
  logic [15:0]                 done_count_o;
  logic                        done_ready_i = 1'b0;
  logic                        busy_o;

  nmcu_matmul_seq dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_base_a_i(cmd_base_a_i), .cmd_base_b_i(cmd_base_b_i), .cmd_base_c_i(cmd_base_c_i),
    .cmd_dim_i(cmd_dim_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_ready_i(instr_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_i(rsp_i), .rsp_ready_o(rsp_ready_o),
    .done_valid_o(done_valid_o), .done_status_o(done_status_o), .done_count_o(done_count_o),
    .done_ready_i(done_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // NMCU model state
  int                      mem [0:65535];
  instr_pkg::instruction_t log_q [$];
  instr_pkg::instruction_t held;
  bit                      pend = 0, stalled = 0, rand_ready = 0, rand_lat = 0, no_rsp = 0;
  int                      lat = 0, lat_cnt = 0, err_at = -1, stable_err = 0, hs_cyc = 0;
  logic [1:0]              pend_status = 2'b00;

  task automatic model_mac(input instr_pkg::instruction_t ins);
    int acc;
    logic [15:0] pa, pb;
    acc = 0;
    pa = ins.addr_a;
    pb = ins.addr_b;
    for (int k = 0; k < int'(ins.len); k++) begin
      acc += mem[pa] * mem[pb];
      pa++;
      pb++;
    end
    mem[ins.addr_c] = acc;
  endtask

  // Handshakes are decided at the negedge, since the values driven here are what the next posedge samples.
  initial begin : nmcu_model
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0; stalled = 0; rsp_valid_i = 1'b0; instr_ready_i = 1'b0;
      end else begin
        if (stalled && instr_valid_o && (instr_o !== held)) stable_err++;
        rsp_valid_i = 1'b0;
        if (pend && !no_rsp) begin
          if (lat_cnt == 0) begin
            rsp_valid_i = 1'b1;
            rsp_i.status = pend_status;
            if (rsp_ready_o) pend = 0;
          end else lat_cnt--;
        end
        instr_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (instr_valid_o && instr_ready_i) begin
          model_mac(instr_o);
          pend_status = (log_q.size() == err_at) ? 2'b01 : 2'b00;
          log_q.push_back(instr_o);
          pend = 1;
          lat_cnt = rand_lat ? $urandom_range(0, 3) : lat;
          hs_cyc = cyc + 1;
          stalled = 0;
        end else begin
          stalled = instr_valid_o;
          held = instr_o;
        end
      end
    end
  end

  task automatic send_cmd(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [7:0] n);
    @(negedge clk);
    log_q.delete();
    cmd_base_a_i = a; cmd_base_b_i = b; cmd_base_c_i = c; cmd_dim_i = n;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit rnd, output logic [1:0] st, output logic [15:0] cnt, output int dcyc);
    bit got;
    got = 0; dcyc = -1; st = 2'bxx; cnt = 'x;
    for (int n = 0; n < bound && !got; n++) begin
      @(negedge clk);
      if (done_valid_o && dcyc < 0) dcyc = cyc;
      done_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done_valid_o && done_ready_i) begin
        st = done_status_o; cnt = done_count_o; got = 1;
      end
    end
    if (!got) check_eq("done_wait_expired", done_valid_o, 1'b1);
    @(negedge clk);
    done_ready_i = 1'b0;
  endtask

  task automatic order_errors(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc, input int n, output int bad);
    logic [15:0] ea, eb, ec;
    bad = 0;
    for (int e = 0; e < log_q.size(); e++) begin
      ea = ba + 16'((e / n) * n);
      eb = bb + 16'((e % n) * n);
      ec = bc + 16'(e);
      if (log_q[e].opcode != instr_pkg::INSTR_MAC || log_q[e].addr_a != ea || log_q[e].addr_b != eb ||
          log_q[e].addr_c != ec || log_q[e].len != 8'(n) || log_q[e].data != '0) bad++;
    end
  endtask

  logic [1:0]  st;
  logic [15:0] cnt;
  int          dcyc, bad;

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = k + 1;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) mem[100 + 4*j + k] = 4*k + j + 1;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", {cmd_ready_o, instr_valid_o, rsp_ready_o, done_valid_o, busy_o}, 5'b10000);
    check_eq("rst_instr_zero", (instr_o == '0), 1'b1);
    check_eq("rst_status", done_status_o, 2'b00);
    check_eq("rst_count", done_count_o, 16'd0);
    rst = 1'b0;

    // 4x4 run
    send_cmd(16'd0, 16'd100, 16'd200, 8'd4);
    check_eq("4x4_valid_k1", instr_valid_o, 1'b1);
    check_eq("4x4_busy", {busy_o, cmd_ready_o}, 2'b10);
    wait_done(400, 0, st, cnt, dcyc);
    check_eq("4x4_status", st, 2'b00);
    check_eq("4x4_count", cnt, 16'd16);
    check_eq("4x4_n_macs", log_q.size(), 16);
    order_errors(16'd0, 16'd100, 16'd200, 4, bad);
    check_eq("4x4_order", bad, 0);
    check_eq("4x4_e12_a", log_q[6].addr_a, 16'd4);
    check_eq("4x4_e12_b", log_q[6].addr_b, 16'd108);
    check_eq("4x4_e12_c", log_q[6].addr_c, 16'd206);
    check_eq("4x4_e12_len", log_q[6].len, 8'd4);
    check_eq("4x4_c00", mem[200], 90);
    check_eq("4x4_c12", mem[206], 254);
    check_eq("4x4_c33", mem[215], 600);

    // N = 0
    send_cmd(16'd0, 16'd100, 16'd200, 8'd0);
    check_eq("n0_done_k1", {done_valid_o, instr_valid_o}, 2'b10);
    wait_done(20, 0, st, cnt, dcyc);
    check_eq("n0_status", st, 2'b00);
    check_eq("n0_count", cnt, 16'd0);
    check_eq("n0_n_macs", log_q.size(), 0);

    // N = MAX_DIM + 1
    send_cmd(16'd0, 16'd100, 16'd200, 8'd9);
    check_eq("n9_done_k1", {done_valid_o, instr_valid_o}, 2'b10);
    wait_done(20, 0, st, cnt, dcyc);
    check_eq("n9_status", st, 2'b10);
    check_eq("n9_count", cnt, 16'd0);
    check_eq("n9_n_macs", log_q.size(), 0);

    // N = 1
    send_cmd(16'd0, 16'd100, 16'd300, 8'd1);
    wait_done(50, 0, st, cnt, dcyc);
    check_eq("n1_status", st, 2'b00);
    check_eq("n1_count", cnt, 16'd1);
    check_eq("n1_n_macs", log_q.size(), 1);
    check_eq("n1_len", log_q[0].len, 8'd1);

    // Error abort on the 3rd MAC
    err_at = 2;
    send_cmd(16'd0, 16'd100, 16'd400, 8'd4);
    wait_done(200, 0, st, cnt, dcyc);
    err_at = -1;
    check_eq("err_status", st, 2'b01);
    check_eq("err_count", cnt, 16'd2);
    check_eq("err_n_macs", log_q.size(), 3);

    // Backpressure and address wrap
    rand_ready = 1; rand_lat = 1;
    send_cmd(16'hFFFE, 16'd100, 16'd500, 8'd4);
    wait_done(2000, 1, st, cnt, dcyc);
    rand_ready = 0; rand_lat = 0;
    check_eq("bp_status", st, 2'b00);
    check_eq("bp_count", cnt, 16'd16);
    check_eq("bp_n_macs", log_q.size(), 16);
    order_errors(16'hFFFE, 16'd100, 16'd500, 4, bad);
    check_eq("bp_order", bad, 0);
    check_eq("bp_stable", stable_err, 0);
    check_eq("bp_wrap_a", log_q[4].addr_a, 16'd2);

    // Reset during WAIT_RSP of element 5
    lat = 3;
    send_cmd(16'd0, 16'd100, 16'd200, 8'd4);
    for (int n = 0; n < 300 && !(log_q.size() == 5 && rsp_ready_o); n++) @(negedge clk);
    check_eq("mid_reached_e5", {log_q.size() == 5, rsp_ready_o}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_ctrl", {cmd_ready_o, instr_valid_o, rsp_ready_o, done_valid_o, busy_o}, 5'b10000);
    check_eq("mid_rst_instr", (instr_o == '0), 1'b1);
    check_eq("mid_rst_stat_cnt", {done_status_o, done_count_o}, 18'd0);
    rst = 1'b0;
    lat = 0;
    send_cmd(16'd0, 16'd100, 16'd200, 8'd2);
    wait_done(100, 0, st, cnt, dcyc);
    check_eq("after_rst_status", st, 2'b00);
    check_eq("after_rst_count", cnt, 16'd4);
    check_eq("after_rst_n_macs", log_q.size(), 4);

`ifdef NMCU_MATMUL_SEQ_TIMEOUT_EN
    no_rsp = 1;
    send_cmd(16'd0, 16'd100, 16'd200, 8'd2);
    wait_done(TMO + 200, 0, st, cnt, dcyc);
    check_eq("tmo_status", st, 2'b11);
    check_eq("tmo_count", cnt, 16'd0);
    check_eq("tmo_cycles", dcyc - hs_cyc, TMO);
    no_rsp = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
